// File: rtl/feed_time_pkg.sv
// Shared types, reset constants and BCD validation rules for the feeder
// time-of-day counter.
package feed_time_pkg;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t h2;
      bcd_t h1;
      bcd_t m2;
      bcd_t m1;
      bcd_t s2;
      bcd_t s1;
   } bcd_time_t;

   typedef struct packed {
      logic pm;
      bcd_t h2;
      bcd_t h1;
      bcd_t m2;
      bcd_t m1;
   } alarm_slot_t;

   localparam bcd_t DIGIT_MAX = 4'd9;
   localparam bcd_t TENS_MAX  = 4'd5;

   localparam bcd_time_t   RESET_TIME_24  = 24'h00_00_00;
   localparam bcd_time_t   RESET_TIME_12  = 24'h12_00_00;
   localparam alarm_slot_t RESET_ALARM_24 = 17'h0_0000;
   localparam alarm_slot_t RESET_ALARM_12 = 17'h0_1200;

   function automatic logic valid_hour(input bcd_t h2, input bcd_t h1, input int hour_mode);
      if (h1 > DIGIT_MAX)
         return 1'b0;
      // 12 h clocks have no hour zero; 24 h clocks stop at 23
      if (hour_mode == 12)
         return (h2 == 4'd0 && h1 != 4'd0) || (h2 == 4'd1 && h1 <= 4'd2);
      return (h2 <= 4'd1) || (h2 == 4'd2 && h1 <= 4'd3);
   endfunction

   function automatic logic valid_sexagesimal(input bcd_t tens, input bcd_t ones);
      return (tens <= TENS_MAX) && (ones <= DIGIT_MAX);
   endfunction

   function automatic logic valid_time(input bcd_time_t t, input int hour_mode);
      return valid_hour(t.h2, t.h1, hour_mode) &&
             valid_sexagesimal(t.m2, t.m1) &&
             valid_sexagesimal(t.s2, t.s1);
   endfunction

   function automatic logic valid_alarm(input alarm_slot_t a, input int hour_mode);
      return valid_hour(a.h2, a.h1, hour_mode) && valid_sexagesimal(a.m2, a.m1);
   endfunction

endpackage

// File: rtl/feed_time_counter_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at {MAX_HI,MAX_LO}; used for seconds and minutes.
module bcd_mod_counter
   import feed_time_pkg::*;
#(
   parameter int MAX_HI = 5,
   parameter int MAX_LO = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic load,
   input  bcd_t load_hi,
   input  bcd_t load_lo,
   output bcd_t hi,
   output bcd_t lo,
   output logic carry
);

   localparam bcd_t HI_TOP = 4'(MAX_HI);
   localparam bcd_t LO_TOP = 4'(MAX_LO);

   logic lo_wrap;

   assign lo_wrap = (lo == LO_TOP);
   assign carry   = inc && lo_wrap && (hi == HI_TOP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (load) begin
         hi <= load_hi;
         lo <= load_lo;
      end else if (inc) begin
         if (lo_wrap) begin
            lo <= '0;
            hi <= (hi == HI_TOP) ? '0 : hi + 4'd1;
         end else begin
            lo <= lo + 4'd1;
         end
      end
   end

endmodule

// File: rtl/feed_time_counter.sv
// BCD time-of-day counter with one-second prescaler, 12/24 h modes,
// validated time load and programmable hh:mm alarm slots.
module feed_time_counter
   import feed_time_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int NUM_ALARMS = 4,
   parameter int HOUR_MODE  = 24,
   localparam int IDX_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Run,
   input  logic                  Load,
   input  logic [23:0]           LoadTime,
   input  logic                  LoadPm,
   input  logic                  AlarmSet,
   input  logic [IDX_W-1:0]      AlarmIdx,
   input  logic [16:0]           AlarmTime,
   input  logic                  AlarmEn,
   output logic [23:0]           Time,
   output logic                  Pm,
   output logic                  SecPulse,
   output logic                  DayPulse,
   output logic [NUM_ALARMS-1:0] AlarmHit,
   output logic                  LoadErr
);

   localparam int          PRE_W       = $clog2(CLK_HZ);
   localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(CLK_HZ - 1);
   localparam bit          MODE_12     = (HOUR_MODE == 12);
   localparam bcd_time_t   RESET_TIME  = MODE_12 ? RESET_TIME_12 : RESET_TIME_24;
   localparam alarm_slot_t RESET_ALARM = MODE_12 ? RESET_ALARM_12 : RESET_ALARM_24;

   if (HOUR_MODE != 24 && HOUR_MODE != 12) begin : g_bad_mode
      $error("feed_time_counter: HOUR_MODE must be 12 or 24");
   end
   if (CLK_HZ < 2) begin : g_bad_clk
      $error("feed_time_counter: CLK_HZ must be at least 2");
   end
   if (NUM_ALARMS < 1 || NUM_ALARMS > 16) begin : g_bad_alarms
      $error("feed_time_counter: NUM_ALARMS must be 1..16");
   end

   bcd_time_t        load_t;
   alarm_slot_t      alarm_in;
   alarm_slot_t      alarm_wr;
   alarm_slot_t      cur_hm;
   logic [PRE_W-1:0] presc;
   logic             load_ok;
   logic             idx_ok;
   logic             alarm_ok;
   logic             tick;
   logic             step;

   bcd_t s2, s1, m2, m1, h2, h1;
   bcd_t h2_nxt, h1_nxt;
   logic pm, pm_nxt, day_roll;
   logic sec_carry, min_carry;

   alarm_slot_t           slot [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] slot_en;
   logic [NUM_ALARMS-1:0] match;

   assign load_t   = bcd_time_t'(LoadTime);
   assign alarm_in = alarm_slot_t'(AlarmTime);
   assign load_ok  = Load && valid_time(load_t, HOUR_MODE);
   assign idx_ok   = int'(AlarmIdx) < NUM_ALARMS;
   assign alarm_ok = AlarmSet && idx_ok && valid_alarm(alarm_in, HOUR_MODE);
   assign tick     = Run && (presc == PRE_TOP);
   // A valid load on the terminal-count edge swallows that second
   assign step     = tick && !load_ok;

   always_comb begin
      alarm_wr    = alarm_in;
      alarm_wr.pm = MODE_12 && alarm_in.pm;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         presc <= '0;
      else if (load_ok)
         presc <= '0;
      else if (Run)
         presc <= tick ? '0 : presc + 1'b1;
   end

   bcd_mod_counter #(.MAX_HI(5), .MAX_LO(9)) u_sec (
      .clk     (Clk),
      .rst     (Reset),
      .inc     (step),
      .load    (load_ok),
      .load_hi (load_t.s2),
      .load_lo (load_t.s1),
      .hi      (s2),
      .lo      (s1),
      .carry   (sec_carry)
   );

   bcd_mod_counter #(.MAX_HI(5), .MAX_LO(9)) u_min (
      .clk     (Clk),
      .rst     (Reset),
      .inc     (sec_carry),
      .load    (load_ok),
      .load_hi (load_t.m2),
      .load_lo (load_t.m1),
      .hi      (m2),
      .lo      (m1),
      .carry   (min_carry)
   );

   always_comb begin
      h2_nxt   = h2;
      h1_nxt   = h1;
      pm_nxt   = pm;
      day_roll = 1'b0;
      if (MODE_12) begin
         // 12 -> 01 keeps the meridiem; 11 -> 12 flips it, and PM -> AM is midnight
         if (h2 == 4'd1 && h1 == 4'd2) begin
            h2_nxt = 4'd0;
            h1_nxt = 4'd1;
         end else if (h2 == 4'd1 && h1 == 4'd1) begin
            h1_nxt   = 4'd2;
            pm_nxt   = !pm;
            day_roll = pm;
         end else if (h1 == DIGIT_MAX) begin
            h2_nxt = 4'd1;
            h1_nxt = 4'd0;
         end else begin
            h1_nxt = h1 + 4'd1;
         end
      end else begin
         if (h2 == 4'd2 && h1 == 4'd3) begin
            h2_nxt   = 4'd0;
            h1_nxt   = 4'd0;
            day_roll = 1'b1;
         end else if (h1 == DIGIT_MAX) begin
            h2_nxt = h2 + 4'd1;
            h1_nxt = 4'd0;
         end else begin
            h1_nxt = h1 + 4'd1;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         h2 <= RESET_TIME.h2;
         h1 <= RESET_TIME.h1;
         pm <= 1'b0;
      end else if (load_ok) begin
         h2 <= load_t.h2;
         h1 <= load_t.h1;
         pm <= MODE_12 && LoadPm;
      end else if (min_carry) begin
         h2 <= h2_nxt;
         h1 <= h1_nxt;
         pm <= pm_nxt;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_ALARMS; i++)
            slot[i] <= RESET_ALARM;
         slot_en <= '0;
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (alarm_ok && AlarmIdx == IDX_W'(i)) begin
               slot[i]    <= alarm_wr;
               slot_en[i] <= AlarmEn;
            end
         end
      end
   end

   assign cur_hm = {pm, h2, h1, m2, m1};

   // Evaluated while SecPulse is high, so only tick-driven arrivals can match
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_ALARMS; i++)
         match[i] = slot_en[i] && (slot[i] == cur_hm) && (s2 == 4'd0) && (s1 == 4'd0);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         SecPulse <= 1'b0;
         DayPulse <= 1'b0;
         LoadErr  <= 1'b0;
         AlarmHit <= '0;
      end else begin
         SecPulse <= step;
         DayPulse <= min_carry && day_roll;
         LoadErr  <= (Load && !load_ok) || (AlarmSet && !alarm_ok);
         AlarmHit <= SecPulse ? match : '0;
      end
   end

   assign Time = {h2, h1, m2, m1, s2, s1};
   assign Pm   = pm;

endmodule

// File: tb/tb_feed_time_counter.sv
// Scoreboard bench for feed_time_counter: a 24 h instance (3 alarm slots)
// and a 12 h instance (2 slots), both with a 4-cycle second.
module tb_feed_time_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        load24, load12;
   logic [23:0] ld_time;
   logic        ld_pm;
   logic        aset24, aset12;
   logic [1:0]  al_idx;
   logic [16:0] al_time;
   logic        al_en;

   logic [23:0] time24, time12;
   logic        pm24, pm12, sec24, sec12, day24, day12, err24, err12;
   logic [2:0]  hit24;
   logic [1:0]  hit12;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [23:0] t;
      logic        pm;
      logic        day;
   } sec_exp_t;

   sec_exp_t   sec_q[$];
   logic [2:0] hit_q[$];

   always #5 clk = ~clk;

   feed_time_counter #(.CLK_HZ(4), .NUM_ALARMS(3), .HOUR_MODE(24)) d24 (
      .Clk(clk), .Reset(rst), .Run(run), .Load(load24), .LoadTime(ld_time), .LoadPm(ld_pm),
      .AlarmSet(aset24), .AlarmIdx(al_idx), .AlarmTime(al_time), .AlarmEn(al_en),
      .Time(time24), .Pm(pm24), .SecPulse(sec24), .DayPulse(day24), .AlarmHit(hit24),
      .LoadErr(err24)
   );

   feed_time_counter #(.CLK_HZ(4), .NUM_ALARMS(2), .HOUR_MODE(12)) d12 (
      .Clk(clk), .Reset(rst), .Run(run), .Load(load12), .LoadTime(ld_time), .LoadPm(ld_pm),
      .AlarmSet(aset12), .AlarmIdx(al_idx[0]), .AlarmTime(al_time), .AlarmEn(al_en),
      .Time(time12), .Pm(pm12), .SecPulse(sec12), .DayPulse(day12), .AlarmHit(hit12),
      .LoadErr(err12)
   );

   function automatic int bcd2sec(input logic [23:0] t, input logic pm, input bit m12);
      int h;
      h = int'(t[23:20]) * 10 + int'(t[19:16]);
      if (m12) h = (h % 12) + (pm ? 12 : 0);
      return h * 3600 + (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
             int'(t[7:4]) * 10 + int'(t[3:0]);
   endfunction

   function automatic logic [23:0] sec2bcd(input int s, input bit m12, output logic pm);
      int h, m, x;
      h  = s / 3600;
      m  = (s / 60) % 60;
      x  = s % 60;
      pm = (h >= 12);
      if (m12) begin
         h = h % 12;
         if (h == 0) h = 12;
      end
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   function automatic sec_exp_t next_exp(input logic [23:0] t, input logic pm, input bit m12);
      sec_exp_t e;
      int       s;
      logic     p;
      s     = (bcd2sec(t, pm, m12) + 1) % 86400;
      e.day = (s == 0);
      e.t   = sec2bcd(s, m12, p);
      e.pm  = m12 ? p : 1'b0;
      return e;
   endfunction

   task automatic test_reset();
      #12;
      n_checks++; if (time24 !== 24'h000000) $display("FAIL reset_time24: got %h want 000000", time24); else n_pass++;
      n_checks++; if (time12 !== 24'h120000 || pm12 !== 1'b0) $display("FAIL reset_time12: got %h pm %b want 120000 pm 0", time12, pm12); else n_pass++;
      n_checks++; if ({sec24, day24, err24, hit24, pm24} !== 7'b0) $display("FAIL reset_out24: got %b want 0", {sec24, day24, err24, hit24, pm24}); else n_pass++;
      n_checks++; if ({sec12, day12, err12, hit12} !== 5'b0) $display("FAIL reset_out12: got %b want 0", {sec12, day12, err12, hit12}); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_rollover_24();
      sec_exp_t    e;
      logic [23:0] t0;
      int          first, second;
      sec_q.delete();
      t0 = 24'h235958;
      ld_time = t0; ld_pm = 1'b0; run = 1'b1; load24 = 1'b1;
      @(posedge clk); #1;
      load24 = 1'b0;
      n_checks++; if (time24 !== t0 || sec24 !== 1'b0) $display("FAIL roll24_load: got %h sec %b want %h sec 0", time24, sec24, t0); else n_pass++;
      e = next_exp(t0, 1'b0, 1'b0); sec_q.push_back(e);
      e = next_exp(e.t, 1'b0, 1'b0); sec_q.push_back(e);
      first = -1; second = -1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (sec24) begin
            if (first < 0) first = c; else second = c;
            n_checks++;
            if (sec_q.size() == 0) $display("FAIL roll24_extra_sec: got pulse at cycle %0d want none", c);
            else begin
               e = sec_q.pop_front();
               if (time24 !== e.t || day24 !== e.day || pm24 !== e.pm)
                  $display("FAIL roll24_tick: got %h day %b pm %b want %h day %b pm %b", time24, day24, pm24, e.t, e.day, e.pm);
               else n_pass++;
            end
         end else begin
            n_checks++; if (day24 !== 1'b0) $display("FAIL roll24_stray_day: got %b want 0", day24); else n_pass++;
         end
      end
      n_checks++; if (first !== 4 || second !== 8) $display("FAIL roll24_spacing: got cycles %0d,%0d want 4,8", first, second); else n_pass++;
      n_checks++; if (sec_q.size() != 0) $display("FAIL roll24_missing: got %0d pending want 0", sec_q.size()); else n_pass++;
   endtask

   task automatic test_12h();
      logic [23:0] tv [3];
      logic        pv [3];
      sec_exp_t    e;
      int          seen;
      tv[0] = 24'h115959; pv[0] = 1'b0;
      tv[1] = 24'h125959; pv[1] = 1'b1;
      tv[2] = 24'h115959; pv[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sec_q.delete();
         ld_time = tv[k]; ld_pm = pv[k]; run = 1'b1; load12 = 1'b1;
         @(posedge clk); #1;
         load12 = 1'b0;
         n_checks++; if (time12 !== tv[k] || pm12 !== pv[k]) $display("FAIL h12_load%0d: got %h pm %b want %h pm %b", k, time12, pm12, tv[k], pv[k]); else n_pass++;
         sec_q.push_back(next_exp(tv[k], pv[k], 1'b1));
         seen = 0;
         for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (sec12) begin
               seen++;
               n_checks++;
               if (sec_q.size() == 0) $display("FAIL h12_extra_sec%0d: got pulse want none", k);
               else begin
                  e = sec_q.pop_front();
                  if (time12 !== e.t || pm12 !== e.pm || day12 !== e.day)
                     $display("FAIL h12_tick%0d: got %h pm %b day %b want %h pm %b day %b", k, time12, pm12, day12, e.t, e.pm, e.day);
                  else n_pass++;
               end
            end
         end
         n_checks++; if (seen != 1) $display("FAIL h12_count%0d: got %0d pulses want 1", k, seen); else n_pass++;
      end
      run = 1'b0;
   endtask

   task automatic test_load_reject();
      logic [23:0] bad [3];
      bit          on12 [3];
      logic [23:0] hold;
      run = 1'b0;
      ld_time = 24'h102030; ld_pm = 1'b0; load24 = 1'b1;
      @(posedge clk); #1;
      load24 = 1'b0;
      ld_time = 24'h083000; ld_pm = 1'b1; load12 = 1'b1;
      @(posedge clk); #1;
      load12 = 1'b0;
      n_checks++; if (err24 !== 1'b0 || err12 !== 1'b0 || time12 !== 24'h083000) $display("FAIL rej_valid: got err %b%b t12 %h want 00 083000", err24, err12, time12); else n_pass++;
      bad[0] = 24'h240000; on12[0] = 1'b0;
      bad[1] = 24'h000000; on12[1] = 1'b1;
      bad[2] = 24'h126000; on12[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         hold = on12[k] ? time12 : time24;
         ld_time = bad[k];
         if (on12[k]) load12 = 1'b1; else load24 = 1'b1;
         @(posedge clk); #1;
         load12 = 1'b0; load24 = 1'b0;
         n_checks++;
         if ((on12[k] ? err12 : err24) !== 1'b1 || (on12[k] ? time12 : time24) !== hold)
            $display("FAIL rej_%0d: got err %b time %h want err 1 time %h", k, on12[k] ? err12 : err24, on12[k] ? time12 : time24, hold);
         else n_pass++;
         @(posedge clk); #1;
         n_checks++; if (err24 !== 1'b0 || err12 !== 1'b0) $display("FAIL rej_pulse%0d: got %b%b want 00", k, err24, err12); else n_pass++;
      end
      al_idx = 2'd3; al_time = {1'b0, 16'h0730}; al_en = 1'b1; aset24 = 1'b1;
      @(posedge clk); #1;
      aset24 = 1'b0;
      n_checks++; if (err24 !== 1'b1) $display("FAIL rej_alarm_idx: got %b want 1", err24); else n_pass++;
   endtask

   task automatic test_alarms();
      logic [2:0] e;
      logic       prev_sec;
      run = 1'b0;
      for (int k = 0; k < 3; k++) begin
         al_idx = 2'(k); al_time = {1'b0, 16'h0730}; al_en = (k != 1); aset24 = 1'b1;
         @(posedge clk); #1;
         aset24 = 1'b0;
         n_checks++; if (err24 !== 1'b0) $display("FAIL alarm_set%0d: got err %b want 0", k, err24); else n_pass++;
      end
      for (int pass = 0; pass < 2; pass++) begin
         hit_q.delete();
         ld_time = (pass == 0) ? 24'h072959 : 24'h073000;
         run = 1'b1; load24 = 1'b1;
         if (pass == 0) begin hit_q.push_back(3'b101); hit_q.push_back(3'b000); end
         else hit_q.push_back(3'b000);
         @(posedge clk); #1;
         load24 = 1'b0;
         prev_sec = 1'b0;
         for (int c = 1; c <= ((pass == 0) ? 10 : 6); c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (prev_sec) begin
               if (hit_q.size() == 0) $display("FAIL alarm_extra%0d: got hit slot with no expectation", pass);
               else begin
                  e = hit_q.pop_front();
                  if (hit24 !== e) $display("FAIL alarm_hit%0d: got %b want %b", pass, hit24, e); else n_pass++;
               end
            end else begin
               if (hit24 !== 3'b000) $display("FAIL alarm_idle%0d: got %b want 000 at cycle %0d", pass, hit24, c); else n_pass++;
            end
            prev_sec = sec24;
         end
         n_checks++; if (hit_q.size() != 0) $display("FAIL alarm_missing%0d: got %0d pending want 0", pass, hit_q.size()); else n_pass++;
      end
      run = 1'b0;
   endtask

   task automatic test_load_tick();
      sec_exp_t e;
      int       at;
      sec_q.delete();
      ld_time = 24'h010203; run = 1'b1; load24 = 1'b1;
      @(posedge clk); #1;
      load24 = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         n_checks++; if (sec24 !== 1'b0) $display("FAIL lt_early: got pulse at cycle %0d want none", c); else n_pass++;
      end
      ld_time = 24'h040506; load24 = 1'b1;
      sec_q.push_back(next_exp(24'h040506, 1'b0, 1'b0));
      @(posedge clk); #1;
      load24 = 1'b0;
      n_checks++; if (time24 !== 24'h040506 || sec24 !== 1'b0) $display("FAIL lt_collide: got %h sec %b want 040506 sec 0", time24, sec24); else n_pass++;
      at = -1;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         if (sec24 && at < 0) begin
            at = c;
            e  = sec_q.pop_front();
            n_checks++; if (time24 !== e.t) $display("FAIL lt_next: got %h want %h", time24, e.t); else n_pass++;
         end
      end
      n_checks++; if (at != 4) $display("FAIL lt_spacing: got cycle %0d want 4", at); else n_pass++;
      run = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit got;
      int hits, secs;
      run = 1'b0;
      al_idx = 2'd0; al_time = {1'b0, 16'h1235}; al_en = 1'b1; aset24 = 1'b1;
      @(posedge clk); #1;
      aset24 = 1'b0;
      ld_time = 24'h123459; run = 1'b1; load24 = 1'b1;
      @(posedge clk); #1;
      load24 = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
         @(posedge clk); #1;
         if (sec24) got = 1'b1;
      end
      n_checks++; if (!got || time24 !== 24'h123500) $display("FAIL rm_arrive: got pulse %b time %h want 1 123500", got, time24); else n_pass++;
      #3 rst = 1'b1;
      #1;
      n_checks++; if (time24 !== 24'h000000 || sec24 !== 1'b0 || time12 !== 24'h120000) $display("FAIL rm_async: got %h sec %b t12 %h want 000000 0 120000", time24, sec24, time12); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (hit24 !== 3'b000) $display("FAIL rm_drop_hit: got %b want 000", hit24); else n_pass++;
      rst = 1'b0;
      ld_time = 24'h123459; load24 = 1'b1;
      @(posedge clk); #1;
      load24 = 1'b0;
      hits = 0; secs = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (sec24) secs++;
         if (hit24 !== 3'b000) hits++;
      end
      n_checks++; if (secs != 2 || hits != 0) $display("FAIL rm_slots_cleared: got %0d secs %0d hits want 2 secs 0 hits", secs, hits); else n_pass++;
      run = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; load24 = 1'b0; load12 = 1'b0; ld_time = '0; ld_pm = 1'b0;
      aset24 = 1'b0; aset12 = 1'b0; al_idx = '0; al_time = '0; al_en = 1'b0;
      test_reset();
      test_rollover_24();
      test_12h();
      test_load_reject();
      test_alarms();
      test_load_tick();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
